instr_issue_sequencer: RTL and testbench
========================================

Name: instr_issue_sequencer

Overview:
- Instruction-side producer for the 4-step control unit: holds a small program memory, fetches 16-bit instruction words and presents each one on `instruction`.
- Drives the 2-bit step counter `current_state` (00→01→10→11) and consumes the control unit's `clear_counter` as the end-of-instruction acknowledge.
- Sits between the program loader/testbench and the control unit. Replaces the free-running step counter and the externally held instruction bus.

Parameters:
- ADDR_WIDTH, 5, program memory address width; DEPTH = 2**ADDR_WIDTH words.
- INSTR_WIDTH, 16, instruction word width. Opcode field is [INSTR_WIDTH-1:INSTR_WIDTH-3].
- ACK_TIMEOUT, 8, maximum cycles spent in step 11 waiting for clear_counter before error.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  pulse; in IDLE, set pc=0 and run continuously.
- step  in  1  pulse; in IDLE, execute exactly one instruction at the current pc.
- halt_req  in  1  level or pulse; latched; stop at the next instruction boundary.
- prog_we  in  1  program write strobe; honoured only in IDLE.
- prog_addr  in  ADDR_WIDTH  program write address.
- prog_data  in  INSTR_WIDTH  program write data.
- clear_counter  in  1  end-of-instruction acknowledge from the control unit.
- instruction  out  INSTR_WIDTH  registered instruction word to the control unit.
- current_state  out  2  registered step index to the control unit.
- pc  out  ADDR_WIDTH  address of the current or next instruction.
- busy  out  1  high in any state other than IDLE.
- halted  out  1  high in IDLE.
- ack_err  out  1  sticky; set on acknowledge timeout, cleared by start or reset.
- retired  out  16  count of acknowledged instructions; wraps at 16'hFFFF.

Behaviour:
- Reset (async, resetn=0):
  - FSM=IDLE; instruction=16'h0000; current_state=2'b00; pc=0; busy=0; halted=1; ack_err=0; retired=0; halt latch=0; step-mode flag=0.
  - Memory contents are NOT reset.
  - Reset mid-instruction aborts it immediately; no partial retire.
- Memory: DEPTH×INSTR_WIDTH register array.
  - Asynchronous read at pc.
  - Synchronous write when prog_we=1 in IDLE. prog_we outside IDLE is ignored.
- States: IDLE, FETCH, S00, S01, S10, S11.
  - current_state = 00 in IDLE, FETCH and S00; 01 in S01; 10 in S10; 11 in S11.
- IDLE:
  - start and step are sampled here only.
  - start → pc=0, ack_err=0, step-mode=0, go to FETCH.
  - step → step-mode=1, go to FETCH.
  - start and step in the same cycle: start wins.
- FETCH (1 cycle): inspect mem[pc] opcode.
  - Opcode 3'b110 (HLT): instruction unchanged, pc unchanged, go to IDLE, no retire.
  - Otherwise: instruction <= mem[pc], go to S00.
- S00 → S01 → S10 → S11: one cycle each, unconditional.
- S11: hold until clear_counter=1 is sampled, or until ACK_TIMEOUT cycles have elapsed.
  - Typical dwell is 2 cycles, because the control unit registers clear_counter.
- On acknowledge:
  - retired++.
  - pc wraps DEPTH-1→0.
  - Go to IDLE if any of: halt latch set; step-mode set; pc was DEPTH-1 (end of program). Clear the halt latch on that transition.
  - Otherwise go to FETCH.
- On timeout: ack_err=1, pc not incremented, no retire, go to IDLE.
- Throughput: 6 cycles per instruction with the registered control unit (FETCH, S00, S01, S10, S11×2).
- instruction is stable from its FETCH load until the next FETCH load; it holds its last value in IDLE.
- clear_counter in any state other than S11 is ignored.
- halt_req during FETCH: the fetched instruction still completes. Asserted in IDLE: the latch is set but has no effect until the next run, which then stops after one instruction.
- busy = !halted at all times.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_NAN=010, OP_OUT=100, OP_LDI=101, OP_REP=111, OP_HLT=110;
  - step encodings STEP_DECODE=00, STEP_OPA=01, STEP_ALU=10, STEP_WB=11;
  - the sequencer state enum.
- One sub-module: prog_mem (register array, sync write, async read).
- FSM, timeout counter and retire counter stay in the top module.

Test Plan:
- Load mem[0]=16'hA400 (LDI), mem[1]=16'h0480 (ADD), mem[2]=16'hC000 (HLT); pulse start; control-unit model acks 1 cycle after seeing 11 → current_state sequence 00,00,01,10,11,11 per instruction; retired=2; halted=1; pc=2; instruction=16'h0480.
- step pulse in IDLE with pc=0 and mem[0]=16'h8000 → exactly one instruction; pc=1; retired=1; busy high for 6 cycles.
- Never assert clear_counter → S11 held 8 cycles; ack_err=1; pc unchanged; retired unchanged; next start clears ack_err.
- halt_req pulsed during S01 of instruction at pc=3, program has no HLT → stops after acknowledge; pc=4; halted=1.
- All 32 words non-HLT, start → 32 retires; pc wraps to 0; halted=1. prog_we during run leaves memory unchanged.
- resetn low during S10 → all outputs at reset values within the same cycle; memory preserved; a subsequent start re-runs the program identically.

Source files
------------

// File: rtl/instr_issue_sequencer_pkg.sv
// Shared definitions for the instruction issue sequencer: opcode field values,
// control-unit step encodings and the sequencer state type.
package instr_issue_sequencer_pkg;

    // Opcode field values (top three bits of an instruction word)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_HLT = 3'b110;
    localparam logic [2:0] OP_REP = 3'b111;

    // Step index presented to the control unit
    localparam logic [1:0] STEP_DECODE = 2'b00;
    localparam logic [1:0] STEP_OPA    = 2'b01;
    localparam logic [1:0] STEP_ALU    = 2'b10;
    localparam logic [1:0] STEP_WB     = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        S00,
        S01,
        S10,
        S11
    } seq_state_t;

    // Step index the control unit sees while the sequencer is in a given state
    function automatic logic [1:0] step_of(input seq_state_t s);
        case (s)
            S01:     return STEP_OPA;
            S10:     return STEP_ALU;
            S11:     return STEP_WB;
            default: return STEP_DECODE;
        endcase
    endfunction

endpackage

// File: rtl/instr_issue_sequencer_prog.sv
// Program memory: register array with synchronous write and asynchronous read.
module prog_mem #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port: the loaded program must survive a reset of the sequencer.
    // NOTE: the array has no reset on purpose; resetting storage would turn it
    // into a huge flop bank with reset fan-out and would wipe the program.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue_sequencer.sv
// Instruction issue sequencer: fetches words from the program memory, presents
// them to the 4-step control unit and walks the step index 00->01->10->11,
// using clear_counter as the end-of-instruction acknowledge.
module instr_issue_sequencer
    import instr_issue_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int INSTR_WIDTH = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   step,
    input  logic                   halt_req,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   clear_counter,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [1:0]             current_state,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   halted,
    output logic                   ack_err,
    output logic [15:0]            retired
);

    localparam int                    TW        = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0]         WAIT_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_LAST   = '1;

    seq_state_t             state;
    seq_state_t             state_next;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic [TW-1:0]          wait_cnt;
    logic                   halt_latch;
    logic                   step_mode;
    logic                   mem_we;
    logic                   fetch_hlt;
    logic                   ack_seen;
    logic                   ack_timeout;
    logic                   run_ends;

    // Program loading is only allowed while nothing is executing
    assign mem_we      = prog_we && (state == IDLE);
    assign fetch_hlt   = (mem_rdata[INSTR_WIDTH-1 -: 3] == OP_HLT);
    // clear_counter only means something while the control unit is in step 11
    assign ack_seen    = (state == S11) && clear_counter;
    assign ack_timeout = (state == S11) && !clear_counter && (wait_cnt == WAIT_LAST);
    // Any of these makes the acknowledged instruction the last one of the run
    assign run_ends    = halt_latch || step_mode || (pc == PC_LAST);
    assign halted      = (state == IDLE);
    assign busy        = !halted;

    prog_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (INSTR_WIDTH)
    ) u_prog_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    // Next-state logic for the fetch / four-step issue sequence
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:  if (start || step) state_next = FETCH;
            FETCH: state_next = fetch_hlt ? IDLE : S00;
            S00:   state_next = S01;
            S01:   state_next = S10;
            S10:   state_next = S11;
            S11: begin
                if (ack_seen) begin
                    state_next = run_ends ? IDLE : FETCH;
                end else if (ack_timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus the registered step index derived from the next state
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: non-blocking assignments for all flops so every register samples
        // pre-edge values regardless of statement order.
        if (!resetn) begin
            state         <= IDLE;
            current_state <= STEP_DECODE;
        end else begin
            state         <= state_next;
            current_state <= step_of(state_next);
        end
    end

    // Cycles spent waiting in step 11 for the acknowledge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == S11) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Program counter, instruction register, run-mode flags and status counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc          <= '0;
            instruction <= '0;
            step_mode   <= 1'b0;
            ack_err     <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc        <= '0;
                        ack_err   <= 1'b0;
                        step_mode <= 1'b0;
                    end else if (step) begin
                        step_mode <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!fetch_hlt) begin
                        instruction <= mem_rdata;
                    end
                end
                S11: begin
                    if (ack_seen) begin
                        retired <= retired + 16'd1;
                        pc      <= pc + ADDR_WIDTH'(1);
                    end else if (ack_timeout) begin
                        ack_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Halt request latch, consumed when a run stops at an acknowledged boundary
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            halt_latch <= 1'b0;
        end else if (ack_seen && run_ends) begin
            halt_latch <= 1'b0;
        end else if (halt_req) begin
            halt_latch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Self-checking bench for instr_issue_sequencer: directed scenarios plus
// randomized programs and run modes, compared against a run-level model.
module tb_instr_issue_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        clear_counter = 1'b0;
    logic [15:0] instruction;
    logic [1:0]  current_state;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;
    logic        ack_err;
    logic [15:0] retired;

    instr_issue_sequencer dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .step          (step),
        .halt_req      (halt_req),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .clear_counter (clear_counter),
        .instruction   (instruction),
        .current_state (current_state),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .ack_err       (ack_err),
        .retired       (retired)
    );

    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Control-unit model: registers "saw step 11" and returns it as clear_counter
    logic cu_en  = 1'b1;
    logic prev11 = 1'b0;

    // Run-level reference model
    logic [15:0] m_mem [32];
    int          m_pc;
    int          m_retired;
    logic        m_ack_err;
    logic [15:0] m_instr;
    logic [1:0]  exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clear_counter = cu_en && prev11;
        prev11 = (current_state == 2'b11);
    endtask

    task automatic model_reset();
        m_pc      = 0;
        m_retired = 0;
        m_ack_err = 1'b0;
        m_instr   = 16'h0000;
        prev11    = 1'b0;
        clear_counter = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"},  instruction, 16'h0000);
        check({tag, "_step"},   current_state, 2'b00);
        check({tag, "_pc"},     pc, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_halted"}, halted, 1);
        check({tag, "_ackerr"}, ack_err, 0);
        check({tag, "_ret"},    retired, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic load(input int addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = addr[4:0];
        prog_data = data;
        tick();
        prog_we   = 1'b0;
        m_mem[addr] = data;
    endtask

    // One run: model the expected step trace and end state, drive the run,
    // record the step index for every busy cycle, then compare.
    task automatic run(input string tag, input bit is_start, input bit cu_on,
                       input bit pre_halt, input int halt_k, input int we_cycle);
        logic [1:0]  got [$];
        logic [15:0] w;
        int          n;
        int          last;
        int          c;
        int          hc;
        int          ns;

        exp_q.delete();
        n = 0;
        if (is_start) begin
            m_pc      = 0;
            m_ack_err = 1'b0;
        end
        for (int g = 0; g < 64; g++) begin
            w = m_mem[m_pc];
            if (w[15:13] == 3'b110) begin
                exp_q.push_back(2'd0);
                break;
            end
            m_instr = w;
            exp_q.push_back(2'd0);
            exp_q.push_back(2'd0);
            exp_q.push_back(2'd1);
            exp_q.push_back(2'd2);
            if (!cu_on) begin
                repeat (8) exp_q.push_back(2'd3);
                m_ack_err = 1'b1;
                break;
            end
            exp_q.push_back(2'd3);
            exp_q.push_back(2'd3);
            m_retired = (m_retired + 1) % 65536;
            last = m_pc;
            m_pc = (m_pc + 1) % 32;
            if (!is_start || pre_halt || n == halt_k || last == 31) break;
            n++;
        end

        cu_en = cu_on;
        if (pre_halt) begin
            halt_req = 1'b1;
            tick();
            halt_req = 1'b0;
        end
        if (is_start) start = 1'b1;
        else          step  = 1'b1;
        tick();
        start = 1'b0;
        step  = 1'b0;
        hc = (halt_k >= 0) ? 6 * halt_k + 2 : -1;
        c = 0;
        while (busy === 1'b1 && c < 300) begin
            got.push_back(current_state);
            if (c == hc) halt_req = 1'b1;
            if (c == we_cycle) begin
                prog_we   = 1'b1;
                prog_addr = 5'd5;
                prog_data = 16'hC000;
            end
            tick();
            halt_req = 1'b0;
            prog_we  = 1'b0;
            c++;
        end

        check({tag, "_ended"}, busy, 0);
        check({tag, "_len"}, got.size(), exp_q.size());
        ns = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < ns; i++) begin
            check($sformatf("%s_st%0d", tag, i), got[i], exp_q[i]);
        end
        check({tag, "_pc"},     pc, m_pc);
        check({tag, "_ret"},    retired, m_retired);
        check({tag, "_ackerr"}, ack_err, m_ack_err);
        check({tag, "_instr"},  instruction, m_instr);
        check({tag, "_halted"}, halted, 1);
    endtask

    initial begin
        logic [15:0] w;
        bit          is_start;
        bit          cu_on;
        int          hk;

        for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        check_reset_outputs("reset");

        // Three-word program ending in HLT
        load(0, 16'hA400);
        load(1, 16'h0480);
        load(2, 16'hC000);
        run("prog3", 1, 1, 0, -1, -1);

        // Single step from pc 0 after reset (program is kept across reset)
        do_reset();
        load(0, 16'h8000);
        run("step1", 0, 1, 0, -1, -1);

        // Acknowledge never arrives, then a fresh start clears the error
        run("tmo", 1, 0, 0, -1, -1);
        run("after_tmo", 1, 1, 0, -1, -1);

        // Full program of non-HLT words
        for (int i = 0; i < 32; i++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b110) w[13] = 1'b1;
            load(i, w);
        end
        run("halt_pc3", 1, 1, 0, 3, -1);
        run("wrap32", 1, 1, 0, -1, 10);
        run("prehalt", 1, 1, 1, -1, -1);

        // Reset while the first instruction is in step 10
        cu_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_s10", current_state, 2'b10);
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        #2;
        resetn = 1'b1;
        model_reset();
        run("rerun", 1, 1, 0, -1, -1);

        // Randomized program edits and run modes
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < $urandom_range(0, 3); k++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 4) == 0) w[15:13] = 3'b110;
                else if (w[15:13] == 3'b110) w[13] = 1'b1;
                load($urandom_range(0, 31), w);
            end
            is_start = ($urandom_range(0, 4) < 2);
            cu_on    = ($urandom_range(0, 7) != 0);
            hk       = (is_start && cu_on && $urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
            run($sformatf("rnd%0d", it), is_start, cu_on, 0, hk, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
